// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 access codes and FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StDone = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication, legality check and
// load-data extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mem_rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        bad_o,
  output logic [31:0] rdata_o
);

  logic [31:0] lane;

  // Decode access size into enables/store data and flag illegal or misaligned accesses.
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = wdata_i;
    bad_o   = 1'b0;
    case (funct3_i)
      F3_B, F3_BU: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = {4{wdata_i[7:0]}};
        bad_o   = we_i & (funct3_i == F3_BU);  // no unsigned stores
      end
      F3_H, F3_HU: begin
        be_o    = 4'b0011 << {offset_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        bad_o   = offset_i[0] | (we_i & (funct3_i == F3_HU));
      end
      F3_W: begin
        be_o  = 4'b1111;
        bad_o = |offset_i;
      end
      default: bad_o = 1'b1;
    endcase
  end

  // Shift the addressed lane down to bit 0 and extend to 32 bits.
  always_comb begin
    lane = mem_rdata_i >> {offset_i, 3'b000};
    case (funct3_i)
      F3_B:    rdata_o = {{24{lane[7]}}, lane[7:0]};
      F3_H:    rdata_o = {{16{lane[15]}}, lane[15:0]};
      F3_BU:   rdata_o = {24'h000000, lane[7:0]};
      F3_HU:   rdata_o = {16'h0000, lane[15:0]};
      default: rdata_o = lane;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns RV32I loads/stores into word-aligned memory requests,
// stalls the core until the memory acknowledges, and returns the extended load data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_i,
  input  logic          req_we_i,
  input  logic [2:0]    funct3_i,
  input  logic [31:0]   addr_i,
  input  logic [31:0]   wdata_i,
  output logic          stall_o,
  output logic          done_o,
  output logic          err_o,
  output logic [31:0]   rdata_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [3:0]    mem_be_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i,
  input  logic          mem_ack_i
);

  lsu_state_e    state_q;
  logic          mem_req_q, mem_we_q, done_q, err_q;
  logic [AW-1:0] mem_addr_q;
  logic [3:0]    mem_be_q;
  logic [31:0]   mem_wdata_q, rdata_q;

  logic [3:0]    be;
  logic [31:0]   wdata_rep, rdata_ext;
  logic          bad;

  // Core holds req_* stable while stalled, so live inputs are valid for extraction in StReq.
  lsu_align u_align (
    .we_i        (req_we_i),
    .funct3_i    (funct3_i),
    .offset_i    (addr_i[1:0]),
    .wdata_i     (wdata_i),
    .mem_rdata_i (mem_rdata_i),
    .be_o        (be),
    .wdata_o     (wdata_rep),
    .bad_o       (bad),
    .rdata_o     (rdata_ext)
  );

  // Access FSM with registered memory-side and completion outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            if (bad) begin
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              state_q <= StDone;
            end else begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_we_i;
              mem_addr_q  <= {addr_i[AW-1:2], 2'b00};
              mem_be_q    <= be;
              mem_wdata_q <= wdata_rep;
              state_q     <= StReq;
            end
          end
        end
        StReq: begin
          if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            rdata_q   <= mem_we_q ? 32'h0 : rdata_ext;
            done_q    <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stall_o     = req_valid_i & (state_q != StDone) & ~rst_i;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
